// File: rtl/game_sprite_motion.sv
// Sprite motion controller: signed X/Y velocity applied on a periodic strobe,
// with a run-time edge policy (free, wrap, bounce, clamp) and edge-hit pulses.
module game_sprite_motion #(
  parameter int unsigned DX_WIDTH                          = 4,
  parameter int unsigned DY_WIDTH                          = 4,
  parameter int unsigned screen_width                      = 640,
  parameter int unsigned screen_height                     = 480,
  parameter int unsigned sprite_w                          = 8,
  parameter int unsigned sprite_h                          = 8,
  parameter int unsigned w_x                               = $clog2(screen_width),
  parameter int unsigned w_y                               = $clog2(screen_height),
  parameter int unsigned strobe_to_update_xy_counter_width = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sprite_write_xy,
  input  logic [w_x-1:0]             sprite_write_x,
  input  logic [w_y-1:0]             sprite_write_y,
  input  logic                       sprite_write_dxy,
  input  logic signed [DX_WIDTH-1:0] sprite_write_dx,
  input  logic signed [DY_WIDTH-1:0] sprite_write_dy,
  input  logic [1:0]                 sprite_edge_mode,
  input  logic                       sprite_enable_update,
  output logic [w_x-1:0]             sprite_x,
  output logic [w_y-1:0]             sprite_y,
  output logic signed [DX_WIDTH-1:0] sprite_dx,
  output logic signed [DY_WIDTH-1:0] sprite_dy,
  output logic                       hit_left,
  output logic                       hit_right,
  output logic                       hit_top,
  output logic                       hit_bottom
);

  localparam int unsigned X_MAX = screen_width - sprite_w;
  localparam int unsigned Y_MAX = screen_height - sprite_h;
  localparam int unsigned NX_W  = w_x + 2;
  localparam int unsigned NY_W  = w_y + 2;
  localparam int unsigned CNT_W = strobe_to_update_xy_counter_width;

  localparam logic signed [NX_W-1:0] X_MAX_S  = NX_W'(X_MAX);
  localparam logic signed [NX_W-1:0] X_SPAN_S = NX_W'(X_MAX + 1);
  localparam logic signed [NY_W-1:0] Y_MAX_S  = NY_W'(Y_MAX);
  localparam logic signed [NY_W-1:0] Y_SPAN_S = NY_W'(Y_MAX + 1);

  typedef enum logic [1:0] {
    EDGE_FREE   = 2'd0,
    EDGE_WRAP   = 2'd1,
    EDGE_BOUNCE = 2'd2,
    EDGE_CLAMP  = 2'd3
  } edge_mode_e;

  // Negation that maps the most-negative velocity to the most-positive one.
  function automatic logic signed [DX_WIDTH-1:0] neg_dx(input logic signed [DX_WIDTH-1:0] v);
    if (v == {1'b1, {(DX_WIDTH-1){1'b0}}}) return {1'b0, {(DX_WIDTH-1){1'b1}}};
    return -v;
  endfunction

  function automatic logic signed [DY_WIDTH-1:0] neg_dy(input logic signed [DY_WIDTH-1:0] v);
    if (v == {1'b1, {(DY_WIDTH-1){1'b0}}}) return {1'b0, {(DY_WIDTH-1){1'b1}}};
    return -v;
  endfunction

  logic [w_x-1:0]             x_q, x_d;
  logic [w_y-1:0]             y_q, y_d;
  logic signed [DX_WIDTH-1:0] dx_q, dx_d;
  logic signed [DY_WIDTH-1:0] dy_q, dy_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       hit_left_q, hit_left_d;
  logic                       hit_right_q, hit_right_d;
  logic                       hit_top_q, hit_top_d;
  logic                       hit_bottom_q, hit_bottom_d;

  edge_mode_e              mode;
  logic                    do_move;
  logic signed [NX_W-1:0]  nx;
  logic signed [NY_W-1:0]  ny;
  logic [w_x-1:0]          wr_x;
  logic [w_y-1:0]          wr_y;

  assign mode = edge_mode_e'(sprite_edge_mode);

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    cnt_d        = cnt_q + CNT_W'(1);
    hit_left_d   = 1'b0;
    hit_right_d  = 1'b0;
    hit_top_d    = 1'b0;
    hit_bottom_d = 1'b0;

    nx = $signed({2'b00, x_q}) + NX_W'(dx_q);
    ny = $signed({2'b00, y_q}) + NY_W'(dy_q);

    // A position write in the update slot suppresses the whole motion step.
    do_move = (cnt_q == {CNT_W{1'b1}}) && sprite_enable_update && !sprite_write_xy;

    wr_x = sprite_write_x;
    wr_y = sprite_write_y;
    if (mode != EDGE_FREE) begin
      if (sprite_write_x > w_x'(X_MAX)) wr_x = w_x'(X_MAX);
      if (sprite_write_y > w_y'(Y_MAX)) wr_y = w_y'(Y_MAX);
    end

    if (do_move) begin
      unique case (mode)
        EDGE_FREE: x_d = w_x'(nx);
        EDGE_WRAP: begin
          x_d = w_x'(nx);
          if (nx > X_MAX_S) begin
            x_d         = w_x'(nx - X_SPAN_S);
            hit_right_d = 1'b1;
          end else if (nx[NX_W-1]) begin
            x_d        = w_x'(nx + X_SPAN_S);
            hit_left_d = 1'b1;
          end
        end
        EDGE_BOUNCE: begin
          x_d = w_x'(nx);
          if (nx > X_MAX_S) begin
            x_d         = w_x'(X_MAX);
            dx_d        = neg_dx(dx_q);
            hit_right_d = 1'b1;
          end else if (nx[NX_W-1]) begin
            x_d        = '0;
            dx_d       = neg_dx(dx_q);
            hit_left_d = 1'b1;
          end
        end
        EDGE_CLAMP: begin
          x_d = w_x'(nx);
          if (nx > X_MAX_S) begin
            x_d         = w_x'(X_MAX);
            dx_d        = '0;
            hit_right_d = 1'b1;
          end else if (nx[NX_W-1]) begin
            x_d        = '0;
            dx_d       = '0;
            hit_left_d = 1'b1;
          end
        end
        default: x_d = x_q;
      endcase

      unique case (mode)
        EDGE_FREE: y_d = w_y'(ny);
        EDGE_WRAP: begin
          y_d = w_y'(ny);
          if (ny > Y_MAX_S) begin
            y_d          = w_y'(ny - Y_SPAN_S);
            hit_bottom_d = 1'b1;
          end else if (ny[NY_W-1]) begin
            y_d       = w_y'(ny + Y_SPAN_S);
            hit_top_d = 1'b1;
          end
        end
        EDGE_BOUNCE: begin
          y_d = w_y'(ny);
          if (ny > Y_MAX_S) begin
            y_d          = w_y'(Y_MAX);
            dy_d         = neg_dy(dy_q);
            hit_bottom_d = 1'b1;
          end else if (ny[NY_W-1]) begin
            y_d       = '0;
            dy_d      = neg_dy(dy_q);
            hit_top_d = 1'b1;
          end
        end
        EDGE_CLAMP: begin
          y_d = w_y'(ny);
          if (ny > Y_MAX_S) begin
            y_d          = w_y'(Y_MAX);
            dy_d         = '0;
            hit_bottom_d = 1'b1;
          end else if (ny[NY_W-1]) begin
            y_d       = '0;
            dy_d      = '0;
            hit_top_d = 1'b1;
          end
        end
        default: y_d = y_q;
      endcase
    end

    if (sprite_write_xy) begin
      x_d = wr_x;
      y_d = wr_y;
    end
    if (sprite_write_dxy) begin
      dx_d = sprite_write_dx;
      dy_d = sprite_write_dy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      cnt_q        <= '0;
      hit_left_q   <= 1'b0;
      hit_right_q  <= 1'b0;
      hit_top_q    <= 1'b0;
      hit_bottom_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      cnt_q        <= cnt_d;
      hit_left_q   <= hit_left_d;
      hit_right_q  <= hit_right_d;
      hit_top_q    <= hit_top_d;
      hit_bottom_q <= hit_bottom_d;
    end
  end

  assign sprite_x   = x_q;
  assign sprite_y   = y_q;
  assign sprite_dx  = dx_q;
  assign sprite_dy  = dy_q;
  assign hit_left   = hit_left_q;
  assign hit_right  = hit_right_q;
  assign hit_top    = hit_top_q;
  assign hit_bottom = hit_bottom_q;

endmodule

// File: tb/tb_game_sprite_motion.sv
// Bench for game_sprite_motion: directed scenarios plus randomized traffic
// checked against an integer-arithmetic model of the motion rules.
module tb_game_sprite_motion;

  localparam int CNT_MAX = 7;
  localparam int X_MAX   = 632;
  localparam int Y_MAX   = 472;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, wxy, wdxy, en;
  logic [9:0]        wx;
  logic [8:0]        wy;
  logic signed [3:0] wdx, wdy;
  logic [1:0]        mode;
  logic [9:0]        sx;
  logic [8:0]        sy;
  logic signed [3:0] sdx, sdy;
  logic              hl, hr, ht, hb;

  int mx, my, mdx, mdy, mcnt;
  bit mhl, mhr, mht, mhb;
  int checks = 0;
  int passes = 0;

  game_sprite_motion #(.strobe_to_update_xy_counter_width(3)) dut (
    .clk(clk), .rst(rst),
    .sprite_write_xy(wxy), .sprite_write_x(wx), .sprite_write_y(wy),
    .sprite_write_dxy(wdxy), .sprite_write_dx(wdx), .sprite_write_dy(wdy),
    .sprite_edge_mode(mode), .sprite_enable_update(en),
    .sprite_x(sx), .sprite_y(sy), .sprite_dx(sdx), .sprite_dy(sdy),
    .hit_left(hl), .hit_right(hr), .hit_top(ht), .hit_bottom(hb)
  );

  function automatic void move_axis(input int md, input int pos, input int vel, input int lim,
                                    input int modulus, output int npos, output int nvel,
                                    output bit lo, output bit hi);
    int n;
    n = pos + vel; npos = n; nvel = vel; lo = 0; hi = 0;
    case (md)
      0: npos = ((n % modulus) + modulus) % modulus;
      1: if (n > lim) begin npos = n - (lim + 1); hi = 1; end
         else if (n < 0) begin npos = n + lim + 1; lo = 1; end
      2: if (n > lim) begin npos = lim; nvel = (vel == -8) ? 7 : -vel; hi = 1; end
         else if (n < 0) begin npos = 0; nvel = (vel == -8) ? 7 : -vel; lo = 1; end
      default: if (n > lim) begin npos = lim; nvel = 0; hi = 1; end
               else if (n < 0) begin npos = 0; nvel = 0; lo = 1; end
    endcase
  endfunction

  // Advance the model by the current inputs, then let the DUT take the same edge.
  task automatic tick();
    int nx, ny, ndx, ndy;
    bit l, r, t, b, upd;
    mhl = 0; mhr = 0; mht = 0; mhb = 0;
    if (rst) begin
      mx = 0; my = 0; mdx = 0; mdy = 0; mcnt = 0;
    end else begin
      upd = (mcnt == CNT_MAX) && en && !wxy;
      ndx = mdx; ndy = mdy;
      if (upd) begin
        move_axis(int'(mode), mx, mdx, X_MAX, 1024, nx, ndx, l, r);
        move_axis(int'(mode), my, mdy, Y_MAX, 512, ny, ndy, t, b);
        mx = nx; my = ny; mhl = l; mhr = r; mht = t; mhb = b;
      end
      if (wxy) begin
        mx = (mode != 0 && int'(wx) > X_MAX) ? X_MAX : int'(wx);
        my = (mode != 0 && int'(wy) > Y_MAX) ? Y_MAX : int'(wy);
      end
      mdx = wdxy ? int'(wdx) : ndx;
      mdy = wdxy ? int'(wdy) : ndy;
      mcnt = (mcnt + 1) % (CNT_MAX + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic load(input int x, input int y, input int dx, input int dy);
    wxy = 1; wdxy = 1; wx = 10'(x); wy = 9'(y); wdx = 4'(dx); wdy = 4'(dy);
    tick();
    wxy = 0; wdxy = 0;
  endtask

  task automatic wait_update();
    int n = 0;
    do begin tick(); n++; end while (mcnt != 0 && n < 2 * (CNT_MAX + 1));
  endtask

  task automatic test_reset();
    en = 1; mode = 2'd0;
    load(77, 33, 3, -2);
    rst = 1; tick(); rst = 0;
    checks++;
    if ({sx, sy, sdx, sdy, hl, hr, ht, hb} !== '0)
      $display("FAIL reset_state: got x=%0d y=%0d dx=%0d dy=%0d hits=%b, want all zero",
               sx, sy, sdx, sdy, {hl, hr, ht, hb});
    else passes++;
    for (int i = 1; i <= 16; i++) begin
      if (i == 1) begin wdxy = 1; wdx = 4'sd1; wdy = 4'sd0; end
      tick();
      wdxy = 0;
      checks++;
      if (sx !== 10'(i / 8))
        $display("FAIL strobe_timing[%0d]: got x=%0d want %0d", i, sx, i / 8);
      else passes++;
    end
  endtask

  task automatic test_free();
    mode = 2'd0; en = 1;
    load(630, 0, 7, -1);
    wait_update();
    checks++;
    if (sx !== 10'd637 || sy !== 9'd511 || {hl, hr, ht, hb} !== 4'b0000)
      $display("FAIL free_1: got x=%0d y=%0d hits=%b want x=637 y=511 hits=0000", sx, sy, {hl, hr, ht, hb});
    else passes++;
    wait_update();
    checks++;
    if (sx !== 10'd644 || sy !== 9'd510 || {hl, hr, ht, hb} !== 4'b0000)
      $display("FAIL free_2: got x=%0d y=%0d hits=%b want x=644 y=510 hits=0000", sx, sy, {hl, hr, ht, hb});
    else passes++;
  endtask

  task automatic test_wrap();
    mode = 2'd1; en = 1;
    load(630, 1, 5, -3);
    wait_update();
    checks++;
    if (sx !== 10'd2 || sy !== 9'd471 || {hl, hr, ht, hb} !== 4'b0110)
      $display("FAIL wrap: got x=%0d y=%0d hits=%b want x=2 y=471 hits=0110", sx, sy, {hl, hr, ht, hb});
    else passes++;
    tick();
    checks++;
    if ({hl, hr, ht, hb} !== 4'b0000)
      $display("FAIL wrap_pulse_width: got hits=%b want 0000", {hl, hr, ht, hb});
    else passes++;
    load(1000, 500, 0, 0);
    checks++;
    if (sx !== 10'd632 || sy !== 9'd472)
      $display("FAIL write_saturate: got x=%0d y=%0d want x=632 y=472", sx, sy);
    else passes++;
    load(627, 5, 5, -5);
    wait_update();
    checks++;
    if (sx !== 10'd632 || sy !== 9'd0 || {hl, hr, ht, hb} !== 4'b0000)
      $display("FAIL land_on_edge: got x=%0d y=%0d hits=%b want x=632 y=0 hits=0000", sx, sy, {hl, hr, ht, hb});
    else passes++;
  endtask

  task automatic test_bounce();
    mode = 2'd2; en = 1;
    load(630, 100, 5, 0);
    wait_update();
    checks++;
    if (sx !== 10'd632 || sdx !== 4'(-5) || {hl, hr, ht, hb} !== 4'b0100)
      $display("FAIL bounce_right: got x=%0d dx=%0d hits=%b want x=632 dx=-5 hits=0100", sx, sdx, {hl, hr, ht, hb});
    else passes++;
    wait_update();
    checks++;
    if (sx !== 10'd627 || {hl, hr, ht, hb} !== 4'b0000)
      $display("FAIL bounce_return: got x=%0d hits=%b want x=627 hits=0000", sx, {hl, hr, ht, hb});
    else passes++;
    load(3, 100, -8, 0);
    wait_update();
    checks++;
    if (sx !== 10'd0 || sdx !== 4'sd7 || {hl, hr, ht, hb} !== 4'b1000)
      $display("FAIL bounce_minneg: got x=%0d dx=%0d hits=%b want x=0 dx=7 hits=1000", sx, sdx, {hl, hr, ht, hb});
    else passes++;
  endtask

  task automatic test_clamp();
    mode = 2'd3; en = 1;
    load(1, 470, -4, 4);
    wait_update();
    checks++;
    if (sx !== 10'd0 || sy !== 9'd472 || sdx !== 4'sd0 || sdy !== 4'sd0 || {hl, hr, ht, hb} !== 4'b1001)
      $display("FAIL clamp_corner: got x=%0d y=%0d dx=%0d dy=%0d hits=%b want 0 472 0 0 1001",
               sx, sy, sdx, sdy, {hl, hr, ht, hb});
    else passes++;
  endtask

  task automatic test_priority();
    int n = 0;
    mode = 2'd2; en = 1;
    load(100, 100, 3, 3);
    while (mcnt != CNT_MAX && n < 16) begin tick(); n++; end
    wxy = 1; wdxy = 1; wx = 10'd200; wy = 9'd50; wdx = 4'(-2); wdy = 4'sd1;
    tick();
    wxy = 0; wdxy = 0;
    checks++;
    if (sx !== 10'd200 || sy !== 9'd50 || sdx !== 4'(-2) || sdy !== 4'sd1 || {hl, hr, ht, hb} !== 4'b0000)
      $display("FAIL write_priority: got x=%0d y=%0d dx=%0d dy=%0d hits=%b want 200 50 -2 1 0000",
               sx, sy, sdx, sdy, {hl, hr, ht, hb});
    else passes++;
    wait_update();
    checks++;
    if (sx !== 10'd198 || sy !== 9'd51)
      $display("FAIL after_priority: got x=%0d y=%0d want x=198 y=51", sx, sy);
    else passes++;
    en = 0;
    wait_update();
    wait_update();
    checks++;
    if (sx !== 10'd198 || sy !== 9'd51)
      $display("FAIL enable_off: got x=%0d y=%0d want x=198 y=51", sx, sy);
    else passes++;
    en = 1;
  endtask

  task automatic test_random();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      wxy  = ($urandom_range(0, 23) == 0);
      wdxy = ($urandom_range(0, 15) == 0);
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: wx = 10'($urandom_range(0, 1023));
        1: wx = 10'($urandom_range(0, 10));
        default: wx = 10'($urandom_range(622, 640));
      endcase
      case ($urandom_range(0, 3))
        0: wy = 9'($urandom_range(0, 511));
        1: wy = 9'($urandom_range(0, 10));
        default: wy = 9'($urandom_range(462, 480));
      endcase
      wdx = 4'($urandom_range(0, 15));
      wdy = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (sx !== 10'(mx) || sy !== 9'(my) || sdx !== 4'(mdx) || sdy !== 4'(mdy) ||
          {hl, hr, ht, hb} !== {mhl, mhr, mht, mhb})
        $display("FAIL random[%0d]: got x=%0d y=%0d dx=%0d dy=%0d hits=%b want x=%0d y=%0d dx=%0d dy=%0d hits=%b",
                 i, sx, sy, sdx, sdy, {hl, hr, ht, hb}, mx, my, mdx, mdy, {mhl, mhr, mht, mhb});
      else passes++;
    end
    rst = 0; wxy = 0; wdxy = 0; en = 1;
  endtask

  initial begin
    rst = 1; wxy = 0; wdxy = 0; en = 0; mode = 2'd0;
    wx = '0; wy = '0; wdx = '0; wdy = '0;
    mx = 0; my = 0; mdx = 0; mdy = 0; mcnt = 0;
    tick(); tick();
    rst = 0;
    test_reset();
    test_free();
    test_wrap();
    test_bounce();
    test_clamp();
    test_priority();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
